cipher_iter: RTL and testbench
==============================

CIPHER_ITER -- requirements
Module: cipher_iter

Interface
REQ-001 The block SHALL have parameter Nk, default 4, meaning key length in 32-bit words; legal values are 4, 6 and 8.
REQ-002 The block SHALL have parameter Nr, default Nk+6, meaning number of rounds.
REQ-003 The block SHALL have port clks, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to encrypt plainText.
REQ-006 The block SHALL have port plainText, input, [0:127]: block to encrypt; bit 0 is the MSB of byte 0.
REQ-007 The block SHALL have port keys, input, [0:128*(Nr+1)-1]: expanded key schedule; round key r is keys[128*r +: 128].
REQ-008 The block SHALL have port busy, output, 1 bit: high while an encryption is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when cipherText becomes valid.
REQ-010 The block SHALL have port cipherText, output, [0:127]: encrypted block, registered.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, ROUND and FINAL.
REQ-012 In IDLE with start=1, the block SHALL, on that edge, load state <= plainText XOR round key 0, set round <= 1, set busy <= 1 and go to ROUND.
REQ-013 In ROUND, each edge SHALL apply SubBytes, ShiftRows, MixColumns and AddRoundKey(keys round) to state, then increment round.
REQ-014 ROUND SHALL go to FINAL on the edge that processes round Nr-1.
REQ-015 In FINAL, one edge SHALL apply SubBytes, ShiftRows and AddRoundKey(round key Nr) without MixColumns, load cipherText, pulse done for one cycle, clear busy and return to IDLE.
REQ-016 Latency SHALL be Nr+1 rising edges from the start-sampling edge to the edge that raises done: 11, 13 or 15 for Nk = 4, 6 or 8.
REQ-017 While busy=1, start SHALL be ignored and plainText SHALL not be sampled.
REQ-018 A start in the cycle where done=1 SHALL be accepted, since the FSM is in IDLE; back-to-back throughput is one block per Nr+1 cycles.
REQ-019 cipherText SHALL hold its value until the next FINAL edge; it SHALL not change during a following encryption.
REQ-020 The round counter SHALL be 4 bits wide and SHALL never exceed Nr.
REQ-021 An Nk value other than 4, 6 or 8 SHALL be an elaboration error.

Reset
REQ-022 reset=0 SHALL immediately, without waiting for a clock, force FSM=IDLE, round=0, busy=0, done=0, cipherText=0 and internal state=0.
REQ-023 A reset asserted mid-operation SHALL abort the encryption; no done pulse SHALL follow for the aborted block.
REQ-024 After reset deasserts, the first rising edge with start=1 SHALL begin a new encryption normally.

Configuration
REQ-025 With macro CIPHER_ITER_KEY_LATCH_EN defined, keys SHALL be copied into an internal register on the start-accepting edge, and all rounds SHALL use the copy; keys may change freely while busy=1.
REQ-026 Without CIPHER_ITER_KEY_LATCH_EN, no key register SHALL exist; rounds SHALL read keys directly, and keys SHALL be held stable from start acceptance through the done edge.

Verification
REQ-027 Nk=4, key 000102030405060708090a0b0c0d0e0f (expanded), plainText 00112233445566778899aabbccddeeff, start pulse -> done on edge 11, cipherText 69c4e0d86a7b0430d8cdb78070b4c55a, busy high for edges 1..11.
REQ-028 Nk=6, key 000102...1617, same plainText -> done on edge 13, cipherText dda97ca4864cdfe06eaf70a0ec0d7191.
REQ-029 Nk=8, key 000102...1e1f, same plainText -> done on edge 15, cipherText 8ea2b7ca516745bfeafc49904b496089.
REQ-030 Nk=4, start held high continuously with plainText changing every cycle -> only the values sampled on acceptance edges are encrypted, every 11 cycles, and cipherText is stable between done pulses.
REQ-031 Nk=4, reset pulsed low at edge 5 of an encryption -> all outputs 0 immediately, no done, and a fresh start then yields 69c4e0d86a7b0430d8cdb78070b4c55a on edge 11.
REQ-032 With CIPHER_ITER_KEY_LATCH_EN, keys driven to all-zero one cycle after start -> cipherText still 69c4e0d86a7b0430d8cdb78070b4c55a.

Source files
------------

// File: rtl/cipher_iter_if.sv
// Handshake and data bundle for the iterative AES encryption core.
// master = requester (drives start/plainText/keys), slave = cipher_iter.
interface cipher_iter_if #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
);
  logic                     start;
  logic [0:127]             plainText;
  logic [0:128*(Nr+1)-1]    keys;
  logic                     busy;
  logic                     done;
  logic [0:127]             cipherText;

  modport master (output start, plainText, keys, input busy, done, cipherText);
  modport slave  (input start, plainText, keys, output busy, done, cipherText);
endinterface

// File: rtl/cipher_iter.sv
// Iterative AES encryption core: one round per clock, Nr+1 cycles per block.
// Optional macro CIPHER_ITER_KEY_LATCH_EN latches the key schedule on start.
module cipher_iter #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic        clks,
  input  logic        reset,
  cipher_iter_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start; cipherText holds last result
  // ROUND | full rounds 1..Nr-1 (with MixColumns)
  // FINAL | last round Nr (no MixColumns), publish result

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("cipher_iter: Nk must be 4, 6 or 8");
  end

  localparam int KW = 128 * (Nr + 1);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

  fsm_t         fsm;
  logic [3:0]   round;
  logic [0:127] state;
  logic [0:127] cipher_q;
  logic         busy_q;
  logic         done_q;
  logic [0:KW-1] key_src;
  logic [0:127] rk_cur, rk_last, sr_out, mc_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [0:127] sub_shift(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(r+4*c) +: 8] = sbox(s[8*(r+4*((c+r)%4)) +: 8]);
    return o;
  endfunction

  function automatic logic [0:127] mix_columns(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

`ifdef CIPHER_ITER_KEY_LATCH_EN
  logic [0:KW-1] key_q;
  assign key_src = key_q;
`else
  assign key_src = bus.keys;
`endif

  assign rk_cur  = key_src[128*int'(round) +: 128];
  assign rk_last = key_src[128*Nr +: 128];
  assign sr_out  = sub_shift(state);
  assign mc_out  = mix_columns(sr_out);

  // Round key 0 always comes straight from the port, so the latched copy
  // is only needed from the first full round onward.
  always_ff @(posedge clks or negedge reset) begin
    if (!reset) begin
      fsm      <= IDLE;
      round    <= 4'd0;
      state    <= '0;
      cipher_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef CIPHER_ITER_KEY_LATCH_EN
      key_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (fsm)
        IDLE: begin
          if (bus.start) begin
            state  <= bus.plainText ^ bus.keys[0 +: 128];
            round  <= 4'd1;
            busy_q <= 1'b1;
            fsm    <= ROUND;
`ifdef CIPHER_ITER_KEY_LATCH_EN
            key_q  <= bus.keys;
`endif
          end
        end
        ROUND: begin
          state <= mc_out ^ rk_cur;
          round <= round + 4'd1;
          if (round == 4'(Nr - 1)) fsm <= FINAL;
        end
        FINAL: begin
          cipher_q <= sr_out ^ rk_last;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          round    <= 4'd0;
          fsm      <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cipherText = cipher_q;
endmodule

// File: tb/tb_cipher_iter.sv
// Directed bench for cipher_iter: table of known AES vectors for Nk=4/6/8
// plus back-to-back, mid-operation reset and (optionally) key-latch sequences.
module tb_cipher_iter;
  logic clks = 1'b0;
  logic reset = 1'b1;
  always #5 clks = ~clks;

  cipher_iter_if #(.Nk(4)) bus4();
  cipher_iter_if #(.Nk(6)) bus6();
  cipher_iter_if #(.Nk(8)) bus8();

  cipher_iter #(.Nk(4)) dut4 (.clks(clks), .reset(reset), .bus(bus4));
  cipher_iter #(.Nk(6)) dut6 (.clks(clks), .reset(reset), .bus(bus6));
  cipher_iter #(.Nk(8)) dut8 (.clks(clks), .reset(reset), .bus(bus8));

  logic         start_v = 1'b0;
  int           sel = 4;
  logic [0:127] pt_v = '0;
  logic [0:1919] kx = '0;
  logic         done_m, busy_m;
  logic [0:127] ct_m;

  assign bus4.start = start_v && (sel == 4);
  assign bus6.start = start_v && (sel == 6);
  assign bus8.start = start_v && (sel == 8);
  assign bus4.plainText = pt_v;
  assign bus6.plainText = pt_v;
  assign bus8.plainText = pt_v;
  assign bus4.keys = kx[0 +: 1408];
  assign bus6.keys = kx[0 +: 1664];
  assign bus8.keys = kx[0 +: 1920];

  always_comb begin
    done_m = bus4.done;
    busy_m = bus4.busy;
    ct_m   = bus4.cipherText;
    case (sel)
      6: begin done_m = bus6.done; busy_m = bus6.busy; ct_m = bus6.cipherText; end
      8: begin done_m = bus8.done; busy_m = bus8.busy; ct_m = bus8.cipherText; end
      default: ;
    endcase
  end

  logic [7:0] sbox_t [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  // FIPS-197 key expansion; key is left-aligned, first 4*nk bytes used.
  function automatic logic [0:1919] expand(input int nk, input logic [0:255] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [0:1919] r;
    int nwords;
    nwords = 4 * (nk + 7);
    rc = 8'h01;
    r  = '0;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < nwords; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < nwords; i++) r[32*i +: 32] = w[i];
    return r;
  endfunction

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  typedef struct {
    int           nk;
    logic [0:255] key;
    logic [0:127] pt;
    logic [0:127] ct;
  } vec_t;

  localparam logic [0:255] KSEQ = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:127] PSEQ = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // Start one block on the selected DUT; returns result, latency and busy shape.
  task automatic encrypt(input int nk, input logic [0:255] key, input logic [0:127] pt,
                         output logic [0:127] ct, output int lat, output bit busy_ok);
    sel = nk;
    kx  = expand(nk, key);
    @(negedge clks);
    pt_v = pt;
    start_v = 1'b1;
    @(negedge clks);
    start_v = 1'b0;
    pt_v = '1;
    lat = 1;
    busy_ok = 1'b1;
    while (!done_m && lat < 40) begin
      if (!busy_m) busy_ok = 1'b0;
      @(negedge clks);
      lat++;
    end
    if (busy_m) busy_ok = 1'b0;
    ct = ct_m;
  endtask

  vec_t vecs[6];
  logic [0:127] ct;
  int lat;
  bit bok;
  bit stable_ok, no_done;
  logic [0:127] junk;

  initial begin
    vecs[0] = '{4, KSEQ, PSEQ, C128};
    vecs[1] = '{6, KSEQ, PSEQ, 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
    vecs[2] = '{8, KSEQ, PSEQ, 128'h8ea2b7ca516745bfeafc49904b496089};
    vecs[3] = '{4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[4] = '{4, 256'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vecs[5] = '{8, 256'h0, 128'h0, 128'hdc95c078a2408989ad48a21492842087};

    #2 reset = 1'b0;
    #1;
    check("reset_busy", {127'h0, bus4.busy}, 128'h0);
    check("reset_done", {127'h0, bus4.done}, 128'h0);
    check("reset_ct",   bus4.cipherText, 128'h0);
    @(negedge clks);
    @(negedge clks);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      encrypt(vecs[i].nk, vecs[i].key, vecs[i].pt, ct, lat, bok);
      check($sformatf("vec%0d_ct", i), ct, vecs[i].ct);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(vecs[i].nk + 7));
      check($sformatf("vec%0d_busy", i), {127'h0, bok}, 128'h1);
      @(negedge clks);
      check($sformatf("vec%0d_done_pulse", i), {127'h0, done_m}, 128'h0);
      check($sformatf("vec%0d_ct_hold", i), ct_m, vecs[i].ct);
    end

    // start held high, plainText changing every cycle; accepts at edges 1, 12, 23
    sel = 4;
    kx = expand(4, KSEQ);
    stable_ok = 1'b1;
    @(negedge clks);
    start_v = 1'b1;
    pt_v = PSEQ;
    for (int e = 1; e <= 33; e++) begin
      @(negedge clks);
      check($sformatf("b2b_done_e%0d", e), {127'h0, done_m},
            {127'h0, (e == 11 || e == 22 || e == 33)});
      if (done_m) check($sformatf("b2b_ct_e%0d", e), ct_m, C128);
      else if (e > 11 && ct_m !== C128) stable_ok = 1'b0;
      junk = {$urandom, $urandom, $urandom, $urandom};
      pt_v = ((e + 1) % 11 == 1) ? PSEQ : junk;
      start_v = (e + 1 <= 23);
    end
    start_v = 1'b0;
    check("b2b_ct_stable", {127'h0, stable_ok}, 128'h1);

    // reset in the middle of a block
    @(negedge clks);
    start_v = 1'b1;
    pt_v = PSEQ;
    @(negedge clks);
    start_v = 1'b0;
    repeat (4) @(negedge clks);
    reset = 1'b0;
    #1;
    check("abort_busy", {127'h0, bus4.busy}, 128'h0);
    check("abort_done", {127'h0, bus4.done}, 128'h0);
    check("abort_ct",   bus4.cipherText, 128'h0);
    @(negedge clks);
    reset = 1'b1;
    no_done = 1'b1;
    repeat (15) begin
      @(negedge clks);
      if (done_m || busy_m) no_done = 1'b0;
    end
    check("abort_no_done", {127'h0, no_done}, 128'h1);
    encrypt(4, KSEQ, PSEQ, ct, lat, bok);
    check("after_abort_ct", ct, C128);
    check("after_abort_latency", 128'(lat), 128'd11);

`ifdef CIPHER_ITER_KEY_LATCH_EN
    sel = 4;
    kx = expand(4, KSEQ);
    @(negedge clks);
    pt_v = PSEQ;
    start_v = 1'b1;
    @(negedge clks);
    start_v = 1'b0;
    kx = '0;
    lat = 1;
    while (!done_m && lat < 40) begin
      @(negedge clks);
      lat++;
    end
    check("latch_ct", ct_m, C128);
    check("latch_latency", 128'(lat), 128'd11);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
